// File: rtl/div_pkg.sv
// Shared types and constants for the divider result collector.
// Optional statistics are enabled by DIV_RESULT_COLLECTOR_STATS_EN (see top).
package div_pkg;
   localparam int DIV_W = 4;
   localparam logic [DIV_W-1:0] DZ_QUOTIENT = '1;

   typedef struct packed {
      logic             dz;
      logic [DIV_W-1:0] q;
      logic [DIV_W-1:0] r;
   } div_result_t;
endpackage

// File: rtl/div_result_fifo.sv
// Small synchronous FIFO of divider results. When empty, the head shows the
// entry popped last, so the outputs hold their final value.
module div_result_fifo
   import div_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_push,
   input  div_result_t i_data,
   input  logic        i_pop,
   output div_result_t o_head,
   output logic [AW:0] o_count,
   output logic        o_empty,
   output logic        o_full
);
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   div_result_t   r_mem [DEPTH];
   logic          w_push, w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_count = r_count;
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);

   // Slot behind the read pointer is the last popped entry until a push reuses the slot.
   assign o_head = o_empty ? r_mem[r_rd_ptr - AW'(1)] : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/div_result_collector.sv
// Tracks ops through a valid shadow of the divider pipeline, buffers results and
// hands out credits. Define DIV_RESULT_COLLECTOR_STATS_EN for pop/dz counters.
module div_result_collector
   import div_pkg::*;
#(
   parameter int W       = DIV_W,
   parameter int LATENCY = 3,
   parameter int DEPTH   = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [W-1:0] i_in_dividend,
   input  logic [W-1:0] i_in_divisor,
   input  logic [W-1:0] i_div_quotient,
   input  logic [W-1:0] i_div_remainder,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [W-1:0] o_out_quotient,
   output logic [W-1:0] o_out_remainder,
   output logic         o_out_dz,
   output logic         o_overflow
`ifdef DIV_RESULT_COLLECTOR_STATS_EN
   ,
   output logic [15:0]  o_res_count,
   output logic [15:0]  o_dz_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(DEPTH + LATENCY + 1) + 1;

   logic [LATENCY-1:0]        r_vld_pipe, r_dz_pipe;
   logic [LATENCY-1:0][W-1:0] r_dvd_pipe;
   logic                      r_overflow;
   logic [SW-1:0]             w_inflight;
   logic [AW:0]               w_count;
   logic                      w_empty, w_full, w_pop;
   div_result_t               w_entry, w_head;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < LATENCY; i++) w_inflight = w_inflight + SW'(r_vld_pipe[i]);
   end

   // Credits count in-flight ops as already occupying the FIFO, so capture never overruns.
   assign o_in_ready = ~w_full & ((SW'(w_count) + w_inflight) < SW'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
         r_dz_pipe  <= '0;
         r_dvd_pipe <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_vld_pipe[0] <= i_in_valid & o_in_ready;
         r_dz_pipe[0]  <= (i_in_divisor == '0);
         r_dvd_pipe[0] <= i_in_dividend;
         for (int i = 1; i < LATENCY; i++) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_dz_pipe[i]  <= r_dz_pipe[i-1];
            r_dvd_pipe[i] <= r_dvd_pipe[i-1];
         end
         if (i_in_valid & ~o_in_ready) r_overflow <= 1'b1;
      end
   end

   always_comb begin
      w_entry = '{dz: 1'b0, q: i_div_quotient, r: i_div_remainder};
      if (r_dz_pipe[LATENCY-1])
         w_entry = '{dz: 1'b1, q: DZ_QUOTIENT, r: r_dvd_pipe[LATENCY-1]};
   end

   assign w_pop = o_out_valid & i_out_ready;

   div_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_vld_pipe[LATENCY-1]),
      .i_data  (w_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign o_out_valid     = ~w_empty;
   assign o_out_quotient  = w_head.q;
   assign o_out_remainder = w_head.r;
   assign o_out_dz        = w_head.dz;
   assign o_overflow      = r_overflow;

`ifdef DIV_RESULT_COLLECTOR_STATS_EN
   logic [15:0] r_res_count, r_dz_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_count <= '0;
         r_dz_count  <= '0;
      end else if (w_pop) begin
         if (r_res_count != 16'hFFFF) r_res_count <= r_res_count + 16'd1;
         if (w_head.dz && r_dz_count != 16'hFFFF) r_dz_count <= r_dz_count + 16'd1;
      end
   end

   assign o_res_count = r_res_count;
   assign o_dz_count  = r_dz_count;
`endif
endmodule

// File: tb/tb_div_result_collector.sv
// Directed bench for div_result_collector with a behavioural 3-stage divider model.
module tb_div_result_collector;
   localparam int W = 4;
   localparam int LAT = 3;

   logic clk = 1'b0, rst_n = 1'b0;
   logic i_in_valid = 1'b0, i_out_ready = 1'b0;
   logic [W-1:0] i_in_dividend = '0, i_in_divisor = '0;
   logic [W-1:0] i_div_quotient, i_div_remainder;
   logic o_in_ready, o_out_valid, o_out_dz, o_overflow;
   logic [W-1:0] o_out_quotient, o_out_remainder;
`ifdef DIV_RESULT_COLLECTOR_STATS_EN
   logic [15:0] o_res_count, o_dz_count;
`endif

   int n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   // Divider model: garbage on zero divisor so the collector must ignore it.
   logic [W-1:0] mq [LAT], mr [LAT];
   always @(posedge clk) begin
      for (int i = LAT-1; i > 0; i--) begin
         mq[i] <= mq[i-1];
         mr[i] <= mr[i-1];
      end
      mq[0] <= (i_in_divisor == 0) ? 4'h5 : i_in_dividend / i_in_divisor;
      mr[0] <= (i_in_divisor == 0) ? 4'hA : i_in_dividend % i_in_divisor;
   end
   assign i_div_quotient  = mq[LAT-1];
   assign i_div_remainder = mr[LAT-1];

   div_result_collector #(.W(W), .LATENCY(LAT), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_in_dividend(i_in_dividend), .i_in_divisor(i_in_divisor),
      .i_div_quotient(i_div_quotient), .i_div_remainder(i_div_remainder),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
      .o_out_quotient(o_out_quotient), .o_out_remainder(o_out_remainder),
      .o_out_dz(o_out_dz), .o_overflow(o_overflow)
`ifdef DIV_RESULT_COLLECTOR_STATS_EN
      , .o_res_count(o_res_count), .o_dz_count(o_dz_count)
`endif
   );

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!o_out_valid && cyc < 20) begin tick(); cyc++; end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; #3;
      n_checks++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", o_in_ready); end
      n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", o_out_valid); end
      n_checks++; if (o_out_quotient !== 4'h0) begin n_fail++; $display("FAIL rst_q got %h want 0", o_out_quotient); end
      n_checks++; if (o_out_remainder !== 4'h0) begin n_fail++; $display("FAIL rst_r got %h want 0", o_out_remainder); end
      n_checks++; if (o_out_dz !== 1'b0) begin n_fail++; $display("FAIL rst_dz got %b want 0", o_out_dz); end
      n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b want 0", o_overflow); end
`ifdef DIV_RESULT_COLLECTOR_STATS_EN
      n_checks++; if (o_res_count !== 16'd0) begin n_fail++; $display("FAIL rst_res_count got %0d want 0", o_res_count); end
      n_checks++; if (o_dz_count !== 16'd0) begin n_fail++; $display("FAIL rst_dz_count got %0d want 0", o_dz_count); end
`endif
   endtask

   task automatic test_single();
      i_out_ready = 1'b1;
      i_in_valid = 1'b1; i_in_dividend = 4'd13; i_in_divisor = 4'd4;
      tick();  // sampling edge (1 of LATENCY+1)
      i_in_valid = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early edge %0d got %b want 0", e, o_out_valid); end
         if (e < 3) tick();
      end
      tick();
      n_checks++; if (o_out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", o_out_valid); end
      n_checks++; if (o_out_quotient !== 4'd3 || o_out_remainder !== 4'd1 || o_out_dz !== 1'b0) begin
         n_fail++; $display("FAIL single_result got q=%0d r=%0d dz=%b want q=3 r=1 dz=0", o_out_quotient, o_out_remainder, o_out_dz); end
      tick();
      n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop got %b want 0", o_out_valid); end
      n_checks++; if (o_out_quotient !== 4'd3 || o_out_remainder !== 4'd1) begin
         n_fail++; $display("FAIL single_hold got q=%0d r=%0d want q=3 r=1", o_out_quotient, o_out_remainder); end
   endtask

   task automatic test_div_zero();
      int cyc;
      i_out_ready = 1'b0;
      i_in_valid = 1'b1; i_in_dividend = 4'd9; i_in_divisor = 4'd0;
      tick();
      i_in_valid = 1'b0; i_in_divisor = 4'd1;
      wait_valid(cyc);
      n_checks++; if (o_out_valid !== 1'b1) begin n_fail++; $display("FAIL dz_timeout got %b want 1", o_out_valid); end
      n_checks++; if (o_out_dz !== 1'b1 || o_out_quotient !== 4'hF || o_out_remainder !== 4'd9) begin
         n_fail++; $display("FAIL dz_result got dz=%b q=%h r=%0d want dz=1 q=f r=9", o_out_dz, o_out_quotient, o_out_remainder); end
      i_out_ready = 1'b1;
      tick();
      n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL dz_pop got %b want 0", o_out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] dv [4] = '{4'd7, 4'd15, 4'd8, 4'd6};
      logic [W-1:0] ds [4] = '{4'd2, 4'd5, 4'd3, 4'd6};
      logic [W-1:0] eq [4] = '{4'd3, 4'd3, 4'd2, 4'd1};
      logic [W-1:0] er [4] = '{4'd1, 4'd0, 4'd2, 4'd0};
      int cyc;
      i_out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         i_in_valid = 1'b1; i_in_dividend = dv[k]; i_in_divisor = ds[k];
         tick();
      end
      i_in_valid = 1'b0;
      wait_valid(cyc);
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (o_out_valid !== 1'b1 || o_out_quotient !== eq[k] || o_out_remainder !== er[k]) begin
            n_fail++; $display("FAIL b2b_%0d got v=%b q=%0d r=%0d want v=1 q=%0d r=%0d", k, o_out_valid, o_out_quotient, o_out_remainder, eq[k], er[k]); end
         tick();
      end
      n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", o_out_valid); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] dv [8] = '{4'd14, 4'd11, 4'd12, 4'd10, 4'd1, 4'd2, 4'd3, 4'd4};
      logic [W-1:0] ds [8] = '{4'd3,  4'd2,  4'd0,  4'd4,  4'd1, 4'd1, 4'd1, 4'd1};
      logic [W-1:0] eq [4] = '{4'd4, 4'd5, 4'hF, 4'd2};
      logic [W-1:0] er [4] = '{4'd2, 4'd1, 4'd12, 4'd2};
      logic         ed [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      int accepted = 0;
      i_out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         i_in_valid = 1'b1; i_in_dividend = dv[k]; i_in_divisor = ds[k];
         if (o_in_ready) accepted++;
         tick();
      end
      i_in_valid = 1'b0;
      n_checks++; if (accepted != 4) begin n_fail++; $display("FAIL bp_accepted got %0d want 4", accepted); end
      n_checks++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", o_in_ready); end
      n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got %b want 1", o_overflow); end
      i_out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (o_out_valid !== 1'b1 || o_out_quotient !== eq[k] || o_out_remainder !== er[k] || o_out_dz !== ed[k]) begin
            n_fail++; $display("FAIL bp_drain_%0d got v=%b q=%0d r=%0d dz=%b want v=1 q=%0d r=%0d dz=%b",
                               k, o_out_valid, o_out_quotient, o_out_remainder, o_out_dz, eq[k], er[k], ed[k]); end
         tick();
      end
      n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra got %b want 0", o_out_valid); end
   endtask

   task automatic test_capture_pop();
      logic [W-1:0] dv [4] = '{4'd15, 4'd9, 4'd5, 4'd0};
      logic [W-1:0] ds [4] = '{4'd2,  4'd3, 4'd7, 4'd0};
      logic [W-1:0] eq [4] = '{4'd7, 4'd3, 4'd0, 4'hF};
      logic [W-1:0] er [4] = '{4'd1, 4'd0, 4'd5, 4'd0};
      i_out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         i_in_valid = 1'b1; i_in_dividend = dv[k]; i_in_divisor = ds[k];
         tick();
      end
      i_in_valid = 1'b0;
      tick(); tick();  // 3 stored, last op in the final shadow stage
      n_checks++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL cp_full_credit got %b want 0", o_in_ready); end
      n_checks++; if (o_out_quotient !== eq[0] || o_out_remainder !== er[0]) begin
         n_fail++; $display("FAIL cp_head0 got q=%0d r=%0d want q=%0d r=%0d", o_out_quotient, o_out_remainder, eq[0], er[0]); end
      i_out_ready = 1'b1;
      tick();  // pop op0 and capture op3 on the same edge
      for (int k = 1; k < 4; k++) begin
         n_checks++; if (o_out_valid !== 1'b1 || o_out_quotient !== eq[k] || o_out_remainder !== er[k]) begin
            n_fail++; $display("FAIL cp_order_%0d got v=%b q=%0d r=%0d want v=1 q=%0d r=%0d", k, o_out_valid, o_out_quotient, o_out_remainder, eq[k], er[k]); end
         tick();
      end
      n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL cp_empty got %b want 0", o_out_valid); end
`ifdef DIV_RESULT_COLLECTOR_STATS_EN
      n_checks++; if (o_res_count !== 16'd14) begin n_fail++; $display("FAIL stats_res got %0d want 14", o_res_count); end
      n_checks++; if (o_dz_count !== 16'd3) begin n_fail++; $display("FAIL stats_dz got %0d want 3", o_dz_count); end
`endif
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      i_out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         i_in_valid = 1'b1; i_in_dividend = 4'd8 + 4'(k); i_in_divisor = 4'd3;
         tick();
      end
      i_in_valid = 1'b0;
      tick();
      rst_n = 1'b0; #2;
      n_checks++; if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_overflow !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_ctrl got rdy=%b v=%b ovf=%b want 1 0 0", o_in_ready, o_out_valid, o_overflow); end
      n_checks++; if (o_out_quotient !== 4'd0 || o_out_remainder !== 4'd0 || o_out_dz !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_data got q=%0d r=%0d dz=%b want 0 0 0", o_out_quotient, o_out_remainder, o_out_dz); end
`ifdef DIV_RESULT_COLLECTOR_STATS_EN
      n_checks++; if (o_res_count !== 16'd0 || o_dz_count !== 16'd0) begin
         n_fail++; $display("FAIL mid_rst_stats got %0d %0d want 0 0", o_res_count, o_dz_count); end
`endif
      tick(); tick();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (o_out_valid) seen++;
         tick();
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_no_results got %0d valid cycles want 0", seen); end
   endtask

   initial begin
      test_reset();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      test_single();
      test_div_zero();
      test_back_to_back();
      test_backpressure();
      test_capture_pop();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
